// File: rtl/minisys_pkg.sv
// Shared definitions for the minisys pipeline: access sizes, MEM-stage state and
// the byte-lane helpers used on the data bus.
package minisys_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int DEFAULT_MAX_WAIT = 15;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Size code 11 falls into the word case everywhere.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: return 4'b0001 << a;
      SZ_HALF: return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the addressed lane out of the bus word and
// sign- or zero-extends it to 32 bits.
module load_align
  import minisys_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{addr, 3'b000} +: 8];
    half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: data = is_unsigned ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      SZ_HALF: data = is_unsigned ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Pipeline MEM stage: runs one load/store at a time on the req/ack data bus,
// flags misaligned and timed-out accesses and registers the MEM/WB values.
module mem_access
  import minisys_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_cp0_data,
  input  logic        ex_mfc0,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_wreg,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_cp0_data,
  output logic        wb_MemIOtoReg,
  output logic        wb_Mfc0,
  output logic        wb_reg_write,
  output logic [4:0]  wb_wreg,
  output logic        addr_err,
  output logic        bus_err,
  output logic        err_store,
  output logic [31:0] bad_vaddr
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  // The cycle in which the counter holds this value is the last one an ack may arrive in.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      addr_reg, alu_reg, cp0_reg;
  logic [1:0]       size_reg;
  logic             unsigned_reg, load_reg, mfc0_reg, reg_write_reg;
  logic [4:0]       wreg_reg;
  logic             accept, is_mem, misaligned, mem_start, ack_done, timeout;
  logic [31:0]      load_data;

  load_align u_load_align (
    .rdata       (mem_rdata),
    .addr        (addr_reg[1:0]),
    .size        (size_reg),
    .is_unsigned (unsigned_reg),
    .data        (load_data)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    ex_ready   = (state_reg == IDLE);
    accept     = ex_valid && ex_ready;
    is_mem     = ex_mem_read || ex_mem_write;
    misaligned = is_misaligned(ex_size, ex_addr[1:0]);
    mem_start  = accept && is_mem && !misaligned;
    ack_done   = (state_reg == WAIT) && mem_ack;
    timeout    = (state_reg == WAIT) && !mem_ack && (cnt_reg == LAST_CNT);
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (mem_start) state_next = WAIT;
      WAIT:    if (ack_done || timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_reg       <= '0;
      addr_reg      <= '0;
      alu_reg       <= '0;
      cp0_reg       <= '0;
      size_reg      <= '0;
      unsigned_reg  <= 1'b0;
      load_reg      <= 1'b0;
      mfc0_reg      <= 1'b0;
      reg_write_reg <= 1'b0;
      wreg_reg      <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_be        <= '0;
      mem_wdata     <= '0;
      wb_valid      <= 1'b0;
      wb_read_data  <= '0;
      wb_alu_result <= '0;
      wb_cp0_data   <= '0;
      wb_MemIOtoReg <= 1'b0;
      wb_Mfc0       <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_wreg       <= '0;
      addr_err      <= 1'b0;
      bus_err       <= 1'b0;
      err_store     <= 1'b0;
      bad_vaddr     <= '0;
    end else begin
      wb_valid <= 1'b0;
      addr_err <= 1'b0;
      bus_err  <= 1'b0;
      if (accept && !mem_start) begin
        // Non-memory and misaligned instructions retire straight from IDLE.
        wb_valid      <= 1'b1;
        wb_read_data  <= '0;
        wb_alu_result <= ex_alu_result;
        wb_cp0_data   <= ex_cp0_data;
        wb_MemIOtoReg <= 1'b0;
        wb_Mfc0       <= ex_mfc0;
        wb_wreg       <= ex_wreg;
        wb_reg_write  <= ex_reg_write && !is_mem;
        if (is_mem) begin
          addr_err  <= 1'b1;
          err_store <= ex_mem_write;
          bad_vaddr <= ex_addr;
        end
      end
      if (mem_start) begin
        cnt_reg       <= '0;
        addr_reg      <= ex_addr;
        alu_reg       <= ex_alu_result;
        cp0_reg       <= ex_cp0_data;
        size_reg      <= ex_size;
        unsigned_reg  <= ex_unsigned;
        load_reg      <= ex_mem_read;
        mfc0_reg      <= ex_mfc0;
        reg_write_reg <= ex_reg_write;
        wreg_reg      <= ex_wreg;
        mem_req       <= 1'b1;
        mem_we        <= ex_mem_write;
        mem_addr      <= {ex_addr[31:2], 2'b00};
        mem_be        <= byte_enable(ex_size, ex_addr[1:0]);
        mem_wdata     <= store_lanes(ex_size, ex_wdata);
      end
      if (ack_done || timeout) begin
        mem_req       <= 1'b0;
        mem_we        <= 1'b0;
        wb_valid      <= 1'b1;
        wb_alu_result <= alu_reg;
        wb_cp0_data   <= cp0_reg;
        wb_Mfc0       <= mfc0_reg;
        wb_wreg       <= wreg_reg;
        wb_read_data  <= (ack_done && load_reg) ? load_data : 32'h0;
        wb_MemIOtoReg <= ack_done && load_reg;
        wb_reg_write  <= ack_done && load_reg && reg_write_reg;
        if (timeout) begin
          bus_err   <= 1'b1;
          err_store <= !load_reg;
          bad_vaddr <= addr_reg;
        end
      end else if (state_reg == WAIT) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: stimulus pushes expected WB results into a
// queue, a negedge monitor pops and compares whenever wb_valid is seen.
module tb_mem_access;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        ex_valid = 1'b0, ex_ready;
  logic        ex_mem_read = 1'b0, ex_mem_write = 1'b0;
  logic [1:0]  ex_size = 2'b00;
  logic        ex_unsigned = 1'b0;
  logic [31:0] ex_addr = '0, ex_wdata = '0, ex_alu_result = '0, ex_cp0_data = '0;
  logic        ex_mfc0 = 1'b0, ex_reg_write = 1'b0;
  logic [4:0]  ex_wreg = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_valid, wb_MemIOtoReg, wb_Mfc0, wb_reg_write;
  logic [31:0] wb_read_data, wb_alu_result, wb_cp0_data, bad_vaddr;
  logic [4:0]  wb_wreg;
  logic        addr_err, bus_err, err_store;

  mem_access #(.MAX_WAIT(15)) dut (
    .clock(clock), .resetn(resetn),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_size(ex_size), .ex_unsigned(ex_unsigned),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_alu_result(ex_alu_result), .ex_cp0_data(ex_cp0_data),
    .ex_mfc0(ex_mfc0), .ex_reg_write(ex_reg_write), .ex_wreg(ex_wreg),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_read_data(wb_read_data),
    .wb_alu_result(wb_alu_result), .wb_cp0_data(wb_cp0_data),
    .wb_MemIOtoReg(wb_MemIOtoReg), .wb_Mfc0(wb_Mfc0),
    .wb_reg_write(wb_reg_write), .wb_wreg(wb_wreg),
    .addr_err(addr_err), .bus_err(bus_err),
    .err_store(err_store), .bad_vaddr(bad_vaddr)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rd, alu, cp0, bad;
    logic        memio, mfc0, rw, aerr, berr, est;
    logic [4:0]  wreg;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_wb = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every WB pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (resetn && wb_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wb_valid", 32'(wb_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_wb++;
        $display("WB #%0d cycle %0d wreg=%0d rd=0x%08h alu=0x%08h aerr=%0b berr=%0b",
                 n_wb, cyc, wb_wreg, wb_read_data, wb_alu_result, addr_err, bus_err);
        chk("wb_cycle", 32'(cyc), 32'(e.cyc));
        chk("wb_alu_result", wb_alu_result, e.alu);
        chk("wb_cp0_data", wb_cp0_data, e.cp0);
        chk("wb_Mfc0", 32'(wb_Mfc0), 32'(e.mfc0));
        chk("wb_wreg", 32'(wb_wreg), 32'(e.wreg));
        chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
        chk("wb_MemIOtoReg", 32'(wb_MemIOtoReg), 32'(e.memio));
        chk("addr_err", 32'(addr_err), 32'(e.aerr));
        chk("bus_err", 32'(bus_err), 32'(e.berr));
        if (e.memio) chk("wb_read_data", wb_read_data, e.rd);
        if (e.aerr || e.berr) begin
          chk("err_store", 32'(err_store), 32'(e.est));
          chk("bad_vaddr", bad_vaddr, e.bad);
        end
      end
    end
  end

  // Drives one instruction at a negedge; it is accepted at the next posedge.
  // acc is the cycle count as seen at the negedge following that accept edge.
  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] alu,
                       input logic rw, input logic [4:0] wreg, output int acc);
    @(negedge clock);
    chk("ex_ready_at_issue", 32'(ex_ready), 32'd1);
    ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr; ex_size = sz; ex_unsigned = uns;
    ex_addr = addr; ex_wdata = wdata; ex_alu_result = alu; ex_cp0_data = alu ^ 32'hFFFF_0000;
    ex_mfc0 = wreg[0]; ex_reg_write = rw; ex_wreg = wreg;
    acc = cyc + 1;
  endtask

  function automatic exp_t mk(input logic [31:0] alu, input logic [4:0] wreg, input logic rw,
                              input int c);
    exp_t e;
    e.rd = '0; e.alu = alu; e.cp0 = alu ^ 32'hFFFF_0000; e.bad = '0;
    e.memio = 1'b0; e.mfc0 = wreg[0]; e.rw = rw; e.aerr = 1'b0; e.berr = 1'b0; e.est = 1'b0;
    e.wreg = wreg; e.cyc = c;
    return e;
  endfunction

  task automatic alu_op(input logic [31:0] alu, input logic [4:0] wreg);
    int acc;
    issue(1'b0, 1'b0, 2'b10, 1'b0, alu, 32'h0, alu, 1'b1, wreg, acc);
    exp_q.push_back(mk(alu, wreg, 1'b1, acc));
  endtask

  // Aligned access; the bench acts as bus slave and acks after k cycles.
  task automatic mem_op(input string nm, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] wreg,
                        input logic [3:0] be, input logic [31:0] lanes,
                        input logic [31:0] rdata, input int k, input logic [31:0] exp_rd);
    int acc;
    exp_t e;
    issue(!wr, wr, sz, uns, addr, wdata, 32'h5000_0000 | addr, 1'b1, wreg, acc);
    e = mk(32'h5000_0000 | addr, wreg, !wr, acc + k);
    e.memio = !wr; e.rd = exp_rd;
    exp_q.push_back(e);
    @(negedge clock);
    ex_valid = 1'b0;
    chk({nm, "_mem_req"}, 32'(mem_req), 32'd1);
    chk({nm, "_mem_we"}, 32'(mem_we), 32'(wr));
    chk({nm, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
    chk({nm, "_mem_be"}, 32'(mem_be), 32'(be));
    if (wr) chk({nm, "_mem_wdata"}, mem_wdata, lanes);
    for (int i = 1; i < k; i++) begin
      chk({nm, "_ex_ready_stall"}, 32'(ex_ready), 32'd0);
      @(negedge clock);
    end
    chk({nm, "_ex_ready_stall"}, 32'(ex_ready), 32'd0);
    chk({nm, "_mem_req_held"}, 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = rdata;
    @(negedge clock);
    mem_ack = 1'b0; mem_rdata = 32'hDEAD_0000;
    chk({nm, "_mem_req_dropped"}, 32'(mem_req), 32'd0);
    chk({nm, "_ex_ready_after"}, 32'(ex_ready), 32'd1);
  endtask

  task automatic misaligned_op(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                               input logic [4:0] wreg);
    int acc;
    exp_t e;
    issue(!wr, wr, sz, 1'b0, addr, 32'h0, 32'h6000_0000 | addr, 1'b1, wreg, acc);
    e = mk(32'h6000_0000 | addr, wreg, 1'b0, acc);
    e.aerr = 1'b1; e.est = wr; e.bad = addr;
    exp_q.push_back(e);
    @(negedge clock);
    ex_valid = 1'b0;
    chk("misaligned_no_req", 32'(mem_req), 32'd0);
    chk("misaligned_ex_ready", 32'(ex_ready), 32'd1);
  endtask

  initial begin
    int acc;
    exp_t e;
    // Reset state, sampled while reset is still asserted.
    @(negedge clock);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_bad_vaddr", bad_vaddr, 32'd0);
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    @(negedge clock);
    resetn = 1'b1;

    // Three back-to-back ALU ops, then lw with a 3-cycle ack delay.
    alu_op(32'h1111_1111, 5'd1);
    alu_op(32'h2222_2222, 5'd2);
    alu_op(32'h3333_3333, 5'd3);
    mem_op("lw", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd4, 4'b1111, 32'h0,
           32'hDEAD_BEEF, 3, 32'hDEAD_BEEF);

    // Loads across lanes and extensions, zero-wait slave.
    mem_op("lb", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd5, 4'b1000, 32'h0,
           32'h80FF_1234, 1, 32'hFFFF_FF80);
    mem_op("lbu", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 5'd6, 4'b1000, 32'h0,
           32'h80FF_1234, 1, 32'h0000_0080);
    mem_op("lh", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 5'd7, 4'b1100, 32'h0,
           32'h80FF_1234, 2, 32'hFFFF_80FF);
    mem_op("lhu", 1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 5'd8, 4'b0011, 32'h0,
           32'h80FF_9234, 1, 32'h0000_9234);

    // Stores.
    mem_op("sh", 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_ABCD, 5'd9, 4'b1100, 32'hABCD_ABCD,
           32'h0, 1, 32'h0);
    mem_op("sb", 1'b1, 2'b00, 1'b0, 32'h201, 32'h1234_565A, 5'd10, 4'b0010, 32'h5A5A_5A5A,
           32'h0, 2, 32'h0);

    // Misaligned load and store.
    misaligned_op(1'b0, 2'b10, 32'h101, 5'd11);
    misaligned_op(1'b1, 2'b01, 32'h203, 5'd12);

    // Store with no ack: request stays up for exactly 15 cycles, then bus_err.
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h300, 32'hCAFE_F00D, 32'h5000_0300, 1'b1, 5'd13, acc);
    e = mk(32'h5000_0300, 5'd13, 1'b0, acc + 15);
    e.berr = 1'b1; e.est = 1'b1; e.bad = 32'h300;
    exp_q.push_back(e);
    @(negedge clock);
    ex_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("timeout_mem_req_high", 32'(mem_req), 32'd1);
      @(negedge clock);
    end
    chk("timeout_mem_req_dropped", 32'(mem_req), 32'd0);
    chk("timeout_ex_ready", 32'(ex_ready), 32'd1);

    // Ack on the last permitted cycle beats the timeout.
    mem_op("lw_late", 1'b0, 2'b10, 1'b0, 32'h304, 32'h0, 5'd14, 4'b1111, 32'h0,
           32'h0123_4567, 15, 32'h0123_4567);

    // Stray ack while idle must not produce a WB pulse.
    @(negedge clock);
    mem_ack = 1'b1;
    @(negedge clock);
    mem_ack = 1'b0;
    repeat (2) @(negedge clock);

    // Reset in the middle of an outstanding load.
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h5000_0400, 1'b1, 5'd15, acc);
    @(negedge clock);
    ex_valid = 1'b0;
    chk("pre_reset_mem_req", 32'(mem_req), 32'd1);
    @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_mem_req", 32'(mem_req), 32'd0);
    chk("async_rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("async_rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("async_rst_bad_vaddr", bad_vaddr, 32'd0);
    @(negedge clock);
    mem_ack = 1'b1;
    resetn = 1'b1;
    @(negedge clock);
    mem_ack = 1'b0;
    repeat (5) @(negedge clock);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the pipeline, directly upstream of the writeback mux. Accepts one instruction at a time from the EX/MEM latch, performs load/store traffic on the data-RAM/I/O bus with a req/ack handshake, aligns and sign/zero-extends load data, detects misaligned and timed-out accesses, and registers the MEM/WB values (read data, ALU result, CP0 data, MemIOtoReg, Mfc0, destination register) consumed by writeback. Stalls upstream while a bus access is outstanding.

## Interface
- MAX_WAIT, 15, bus cycles allowed for mem_ack before abort (1..255)
- clock  in  1  pipeline clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX/MEM holds a valid instruction
- ex_ready  out  1  stage can accept (state IDLE); ~ex_ready is the pipeline stall
- ex_mem_read / ex_mem_write  in  1  load / store (never both)
- ex_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- ex_unsigned  in  1  zero-extend load (lbu/lhu)
- ex_addr  in  32  effective address (= ALU result for memory ops)
- ex_wdata  in  32  store data (rt)
- ex_alu_result, ex_cp0_data  in  32  pass-through to WB
- ex_mfc0, ex_reg_write  in  1  pass-through controls
- ex_wreg  in  5  destination register
- mem_req  out  1  bus request, held until ack or abort
- mem_we  out  1  write strobe
- mem_addr  out  32  {ex_addr[31:2], 2'b00}
- mem_be  out  4  byte enables, little-endian
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  bus completion; mem_rdata valid when high for reads
- mem_rdata  in  32  bus read data
- wb_valid  out  1  one-cycle pulse: WB outputs valid
- wb_read_data, wb_alu_result, wb_cp0_data  out  32  to writeback mux
- wb_MemIOtoReg, wb_Mfc0, wb_reg_write  out  1  to writeback / register file
- wb_wreg  out  5  register file write address
- addr_err, bus_err  out  1  one-cycle pulses, coincident with wb_valid
- err_store  out  1  faulting access was a store
- bad_vaddr  out  32  faulting address (held until next error)

## Operation
- States: IDLE, WAIT. Reset: IDLE; all outputs 0.
- Accept when ex_valid & ex_ready. Latch address, size, controls, pass-through fields.
- Non-memory instruction: stay IDLE; WB registers loaded at accept edge, wb_MemIOtoReg=0.
- Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no bus request; addr_err=1, err_store=ex_mem_write, bad_vaddr=ex_addr, wb_reg_write forced 0.
- Aligned memory op: IDLE->WAIT; mem_req=1, mem_we=ex_mem_write, mem_be: byte 0001<<addr[1:0], half addr[1]?1100:0011, word 1111; mem_wdata byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- WAIT, mem_ack=1: ->IDLE, drop mem_req; loads: select lane by addr[1:0], sign-extend unless ex_unsigned; wb_MemIOtoReg=1; stores: wb_reg_write=0.
- WAIT, counter reaches MAX_WAIT without ack: ->IDLE, drop mem_req, bus_err=1, bad_vaddr=addr, wb_reg_write=0.
- Ack on the final permitted cycle wins over timeout. mem_ack in IDLE ignored.

## Timing
- Non-memory / misaligned: wb_valid high the cycle after accept; ex_ready stays 1 (back-to-back).
- Memory: accept at edge N; mem_req high from N; ack sampled at edge N+k (k>=1); wb_valid high cycle after N+k; ex_ready=0 from N to N+k. Zero-wait slave: wb_valid 2 cycles after accept.
- Wait counter cleared on entering WAIT, increments each WAIT cycle; abort at edge where count==MAX_WAIT.
- Bus outputs stable while mem_req high.
- Reset asserted mid-access: mem_req, wb_valid drop immediately (async); no WB pulse for the aborted access.
- No downstream backpressure: WB always consumes.

## Structure
- Shared package minisys_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state enum, default MAX_WAIT.
- Sub-module load_align: combinational lane select + sign/zero extension (rdata, addr[1:0], size, unsigned -> 32-bit).
- Counter width ceil(log2(MAX_WAIT+1)).

## Test plan
- lb addr 0x103, rdata 0x80FF_1234, ack next cycle -> wb_read_data 0xFFFF_FF80, mem_be 1000, wb_valid 2 cycles after accept; lbu -> 0x0000_0080.
- sh addr 0x202, wdata 0x0000_ABCD -> mem_be 1100, mem_wdata 0xABCD_ABCD, mem_we=1, wb_reg_write=0.
- lw addr 0x101 -> no mem_req, addr_err pulse, bad_vaddr 0x101, err_store=0, wb_reg_write=0.
- sw with mem_ack never asserted, MAX_WAIT=15 -> mem_req high 15 cycles, bus_err pulse, err_store=1, ex_ready back to 1.
- Three back-to-back ALU ops then lw with 3-cycle ack delay -> three consecutive wb_valid pulses, ex_ready low for 3 cycles, ack on cycle 15 beats timeout.
- resetn low while in WAIT -> mem_req 0 within same cycle, state IDLE, no wb_valid after release.
